mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 27 ++
 rtl/scan_dwell_cnt.sv | 52 +++++
 rtl/mux_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the 4:1 MUX scan sequencer: FSM states, channel
// codes and the default settle interval.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int DEFAULT_SETTLE = 2;

    function automatic logic [1:0] next_chan(input logic [1:0] chan);
        case (chan)
            CH_A:    return CH_B;
            CH_B:    return CH_C;
            CH_C:    return CH_D;
            default: return CH_A;
        endcase
    endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Per-channel window counter: captures W = max(dwell, SETTLE+1) on load and
// flags the cycle where the running count reaches W.
module scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = DEFAULT_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_w,
    input  logic               restart,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tc
);

    // Wide enough for both the widest dwell and SETTLE+1, so W never wraps.
    localparam int CW = (DWELL_W + 1 > $clog2(SETTLE + 2)) ? DWELL_W + 1 : $clog2(SETTLE + 2);
    localparam logic [CW-1:0] MIN_W = CW'(SETTLE + 1);

    logic [CW-1:0] dwell_ext;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        dwell_ext = CW'(dwell);
        win_d     = win_q;
        cnt_d     = cnt_q;
        if (load_w) begin
            win_d = (dwell_ext > MIN_W) ? dwell_ext : MIN_W;
        end
        if (restart) begin
            cnt_d = CW'(1);
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == win_q);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 MUX: steps the selects through A..D, samples O at the
// end of each window and publishes the 4-bit sweep result with done/valid.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = DEFAULT_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               O,
    output logic               S0,
    output logic               S1,
    output logic               busy,
    output logic               done,
    output logic [3:0]         result,
    output logic               valid
);

    state_e     state_q, state_d;
    logic [1:0] chan_q, chan_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] result_q, result_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       valid_q, valid_d;
    logic       mode_q, mode_d;
    logic       stop_seen_q, stop_seen_d;

    logic       cnt_load;
    logic       cnt_restart;
    logic       cnt_en;
    logic       cnt_tc;

    scan_dwell_cnt #(
        .DWELL_W (DWELL_W),
        .SETTLE  (SETTLE)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_w  (cnt_load),
        .restart (cnt_restart),
        .en      (cnt_en),
        .dwell   (dwell),
        .tc      (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        mode_d      = mode_q;
        stop_seen_d = stop_seen_q;
        cnt_load    = 1'b0;
        cnt_restart = 1'b0;
        cnt_en      = 1'b0;

        if (busy_q && stop) begin
            stop_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = mode_cont;
                    stop_seen_d = 1'b0;
                    chan_d      = CH_A;
                    sel_d       = CH_A;
                    busy_d      = 1'b1;
                    valid_d     = 1'b0;
                    cnt_load    = 1'b1;
                    cnt_restart = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    shadow_d[chan_q] = O;
                    cnt_restart      = 1'b1;
                    if (chan_q == CH_D) begin
                        state_d = DONE;
                    end else begin
                        chan_d = next_chan(chan_q);
                        sel_d  = next_chan(chan_q);
                    end
                end
            end
            DONE: begin
                result_d = shadow_q;
                valid_d  = 1'b1;
                done_d   = 1'b1;
                // A stop arriving in this very cycle still ends the run.
                if (mode_q && !(stop_seen_q || stop)) begin
                    chan_d      = CH_A;
                    sel_d       = CH_A;
                    cnt_restart = 1'b1;
                    state_d     = SCAN;
                end else begin
                    busy_d      = 1'b0;
                    stop_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= CH_A;
            sel_q       <= CH_A;
            shadow_q    <= 4'b0000;
            result_q    <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            mode_q      <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            mode_q      <= mode_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    assign S0     = sel_q[0];
    assign S1     = sel_q[1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving a behavioural 4:1 MUX model.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic       O;
    logic       S0, S1, busy, done, valid;
    logic [3:0] result;

    logic [3:0] mux_in = 4'b0000;   // {D,C,B,A}
    logic       tog_mode = 1'b0;
    logic       tog = 1'b0;
    logic [3:0] exp6;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;
    always @(negedge clk) tog <= ~tog;

    assign O = tog_mode ? tog : mux_in[{S1, S0}];

    mux_scan_ctrl #(
        .DWELL_W (8),
        .SETTLE  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dwell     (dwell),
        .O         (O),
        .S0        (S0),
        .S1        (S1),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .valid     (valid)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 8'(busy), 8'd1);
        chk("start_valid", 8'(valid), 8'd0);
        chk("start_sel", 8'({S1, S0}), 8'd0);
        chk("start_done", 8'(done), 8'd0);
    endtask

    // Walks one sweep cycle by cycle after its start (or restart) edge.
    task automatic sweep(input int w, input logic [3:0] exp_res, input logic cont_end,
                         input int glitch_j, input logic [3:0] glitch_mask,
                         input int start_j1, input int start_j2, input int stop_j);
        for (int j = 1; j <= 4 * w + 1; j++) begin
            tick();
            if (j <= 4 * w) begin
                chk("sel", 8'({S1, S0}), 8'((j < 4 * w) ? j / w : 3));
                chk("busy_run", 8'(busy), 8'd1);
            end
            chk("done", 8'(done), 8'(j == 4 * w + 1));
            start = (j == start_j1) || (j == start_j2);
            stop  = (j == stop_j);
            if (j == glitch_j) mux_in = mux_in ^ glitch_mask;
        end
        start = 1'b0;
        stop  = 1'b0;
        chk("result", 8'(result), 8'(exp_res));
        chk("valid", 8'(valid), 8'd1);
        chk("busy_end", 8'(busy), 8'(cont_end));
        chk("sel_end", 8'({S1, S0}), cont_end ? 8'd0 : 8'd3);
    endtask

    initial begin
        // Reset state
        #23;
        chk("rst_sel", 8'({S1, S0}), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_result", 8'(result), 8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        #4 rst_n = 1'b1;
        tick();

        // 1: single sweep, W=4; dwell/mode changes while busy are ignored
        mux_in = 4'b1101;
        dwell = 8'd4;
        mode_cont = 1'b0;
        do_start();
        dwell = 8'd9;
        mode_cont = 1'b1;
        sweep(4, 4'b1101, 1'b0, 0, 4'b0000, 0, 0, 0);

        // 2: dwell=0 -> W=3; A flips after its sample, result unaffected
        dwell = 8'd0;
        mode_cont = 1'b0;
        do_start();
        sweep(3, 4'b1101, 1'b0, 4, 4'b0001, 0, 0, 0);
        mux_in = 4'b1101;

        // 3: continuous, inputs inverted between sweeps, stop during sweep 2
        dwell = 8'd4;
        mode_cont = 1'b1;
        do_start();
        sweep(4, 4'b1101, 1'b1, 16, 4'b1111, 0, 0, 0);
        sweep(4, 4'b0010, 1'b0, 0, 4'b0000, 0, 0, 5);
        tick();
        chk("t3_idle_busy", 8'(busy), 8'd0);
        chk("t3_idle_done", 8'(done), 8'd0);
        chk("t3_idle_sel", 8'({S1, S0}), 8'd3);

        // 4: start re-pulsed at cycles 3 and 6 of a running sweep
        mux_in = 4'b1011;
        mode_cont = 1'b0;
        do_start();
        sweep(4, 4'b1011, 1'b0, 0, 4'b0000, 2, 5, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_no_done", 8'(done), 8'd0);
            chk("t4_idle_busy", 8'(busy), 8'd0);
        end

        // 5: asynchronous reset while channel 2 is selected
        mux_in = 4'b1101;
        do_start();
        for (int k = 0; k < 9; k++) tick();
        chk("t5_sel_ch2", 8'({S1, S0}), 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_sel", 8'({S1, S0}), 8'd0);
        chk("t5_rst_busy", 8'(busy), 8'd0);
        chk("t5_rst_valid", 8'(valid), 8'd0);
        chk("t5_rst_result", 8'(result), 8'd0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("t5_stay_idle", 8'(busy), 8'd0);
        mux_in = 4'b0110;
        do_start();
        sweep(4, 4'b0110, 1'b0, 0, 4'b0000, 0, 0, 0);

        // 6: O toggles every cycle, dwell=5 -> samples alternate
        tog_mode = 1'b1;
        dwell = 8'd5;
        exp6 = tog ? 4'b0101 : 4'b1010;
        do_start();
        sweep(5, exp6, 1'b0, 0, 4'b0000, 0, 0, 0);
        tog_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
